// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
//   state_e     - sequencer phase: hold all domains, staged release, running
//   CAUSE_*     - bit positions within the sticky rst_cause vector
package reset_seq_pkg;

  typedef enum logic [1:0] {
    StHold    = 2'd0,
    StRelease = 2'd1,
    StRun     = 2'd2
  } state_e;

  localparam int unsigned CAUSE_EXT = 0;
  localparam int unsigned CAUSE_SW  = 1;
  localparam int unsigned CAUSE_WDT = 2;
  localparam int unsigned CAUSE_W   = 3;

endpackage

// File: rtl/reset_sequencer_btn_debounce.sv
// Button conditioner: 2-FF synchronizer followed by a stability counter.
//   clk, rst        - system clock, synchronous active-high reset
//   btn_n_i         - asynchronous button, active low
//   ext_level_o     - debounced "button pressed" level
// The level flips once the synchronized value has disagreed with it for DEBOUNCE
// consecutive cycles; ext_level_o shows the new level in the DEBOUNCE-th
// disagreeing cycle (the registered level follows one cycle later).
module btn_debounce #(
  parameter int unsigned DEBOUNCE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic ext_level_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE + 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            diff, flip;

  assign diff = ~sync2_q != level_q;
  assign flip = diff && (cnt_q == CntW'(DEBOUNCE - 1));

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (!diff) begin
      cnt_d = '0;             // any agreement restarts the stability window
    end else if (flip) begin
      cnt_d   = '0;
      level_d = ~level_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ext_level_o = level_q ^ flip;

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller for the always-on domain.
//   clk, rst          - system clock, synchronous active-high reset
//   ext_rst_btn_n     - asynchronous external reset button, active low
//   sw_rst_req        - single-cycle software reset request
//   wdt_rst_req       - single-cycle watchdog reset request
//   cause_clr         - single-cycle clear of rst_cause
//   rst_out_n         - per-domain active-low reset requests, bit 0 released first
//   rst_cause         - sticky cause bits {wdt, sw, ext}
//   busy              - high while any domain is held in reset
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = 3,
  parameter int unsigned STRETCH     = 16,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned DEBOUNCE    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ext_rst_btn_n,
  input  logic                   sw_rst_req,
  input  logic                   wdt_rst_req,
  input  logic                   cause_clr,
  output logic [NUM_DOMAINS-1:0] rst_out_n,
  output logic [CAUSE_W-1:0]     rst_cause,
  output logic                   busy
);

  localparam int unsigned CntMax = (STRETCH > STAGE_GAP) ? STRETCH : STAGE_GAP;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned IdxW   = $clog2(NUM_DOMAINS) + 1;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] out_q, out_d;
  logic [CAUSE_W-1:0]     cause_q, cause_d;
  logic [CAUSE_W-1:0]     cause_set;
  logic                   ext_level;
  logic                   req;

  btn_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_btn_debounce (
    .clk         (clk),
    .rst         (rst),
    .btn_n_i     (ext_rst_btn_n),
    .ext_level_o (ext_level)
  );

  assign req = sw_rst_req | wdt_rst_req | ext_level;

  always_comb begin
    cause_set            = '0;
    cause_set[CAUSE_EXT] = ext_level;
    cause_set[CAUSE_SW]  = sw_rst_req;
    cause_set[CAUSE_WDT] = wdt_rst_req;
    // A clear coinciding with a request keeps only the new request's bit.
    cause_d = cause_clr ? cause_set : (cause_q | cause_set);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      StHold: begin
        if (req) begin
          cnt_d = '0;
        end else if (cnt_q == CntW'(STRETCH - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = (NUM_DOMAINS == 1) ? StRun : StRelease;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRelease: begin
        if (req) begin
          cnt_d   = '0;
          state_d = StHold;
        end else if (cnt_q == CntW'(STAGE_GAP - 1)) begin
          cnt_d = '0;
          // Releasing the last domain is the same cycle busy drops, so go
          // straight to RUN instead of bumping idx first.
          if (idx_q == IdxW'(NUM_DOMAINS - 2)) state_d = StRun;
          else                                 idx_d   = idx_q + IdxW'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        if (req) begin
          cnt_d   = '0;
          state_d = StHold;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StHold;
      end
    endcase
  end

  // Outputs are registered from the next state so the domain resets are glitch-free.
  always_comb begin
    out_d = '0;
    unique case (state_d)
      StRun:     out_d = '1;
      StRelease: begin
        for (int i = 0; i < NUM_DOMAINS; i++) out_d[i] = (IdxW'(i) <= idx_d);
      end
      default:   out_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StHold;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      cause_q <= cause_d;
    end
  end

  assign rst_out_n = out_q;
  assign rst_cause = cause_q;
  assign busy      = ~&out_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters. Cycle n is the
// interval after the n-th rising edge; inputs are driven and outputs sampled
// 1 time unit after that edge.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ext_rst_btn_n;
  logic       sw_rst_req;
  logic       wdt_rst_req;
  logic       cause_clr;
  logic [2:0] rst_out_n;
  logic [2:0] rst_cause;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_DOMAINS (3),
    .STRETCH     (16),
    .STAGE_GAP   (4),
    .DEBOUNCE    (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ext_rst_btn_n (ext_rst_btn_n),
    .sw_rst_req    (sw_rst_req),
    .wdt_rst_req   (wdt_rst_req),
    .cause_clr     (cause_clr),
    .rst_out_n     (rst_out_n),
    .rst_cause     (rst_cause),
    .busy          (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance to cycle n, dropping single-cycle pulses after the cycle they were set in.
  task automatic run_to(input int n);
    while (cyc < n) begin
      tick();
      sw_rst_req  = 1'b0;
      wdt_rst_req = 1'b0;
      cause_clr   = 1'b0;
    end
  endtask

  task automatic check_out(input string tag, input int n, input logic [2:0] o,
                           input logic b);
    run_to(n);
    check_eq({tag, "_out"}, {29'd0, rst_out_n}, {29'd0, o});
    check_eq({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
  endtask

  initial begin
    rst           = 1'b1;
    ext_rst_btn_n = 1'b1;
    sw_rst_req    = 1'b0;
    wdt_rst_req   = 1'b0;
    cause_clr     = 1'b0;

    // Power-up: rst high in cycles 0-1.
    run_to(2);
    rst = 1'b0;
    check_out("por_c2", 2, 3'b000, 1'b1);
    check_eq("por_cause", {29'd0, rst_cause}, 32'd0);
    check_out("por_c17", 17, 3'b000, 1'b1);
    check_out("por_c18", 18, 3'b001, 1'b1);
    check_out("por_c21", 21, 3'b001, 1'b1);
    check_out("por_c22", 22, 3'b011, 1'b1);
    check_out("por_c25", 25, 3'b011, 1'b1);
    check_out("por_c26", 26, 3'b111, 1'b0);
    check_eq("por_cause_end", {29'd0, rst_cause}, 32'd0);

    // Software pulse in RUN.
    run_to(100);
    sw_rst_req = 1'b1;
    check_out("sw_c101", 101, 3'b000, 1'b1);
    check_eq("sw_cause", {29'd0, rst_cause}, 32'b010);
    check_out("sw_c116", 116, 3'b000, 1'b1);
    check_out("sw_c117", 117, 3'b001, 1'b1);

    // Watchdog pulse one cycle after bit0 release.
    run_to(118);
    wdt_rst_req = 1'b1;
    check_out("wdt_c119", 119, 3'b000, 1'b1);
    check_eq("wdt_cause", {29'd0, rst_cause}, 32'b110);
    check_out("wdt_c134", 134, 3'b000, 1'b1);
    check_out("wdt_c135", 135, 3'b001, 1'b1);
    check_out("wdt_c143", 143, 3'b111, 1'b0);

    // Cause clear alone, then clear together with a software request.
    run_to(150);
    cause_clr = 1'b1;
    run_to(151);
    check_eq("clr_alone", {29'd0, rst_cause}, 32'b000);
    check_eq("clr_alone_out", {29'd0, rst_out_n}, 32'b111);
    run_to(160);
    cause_clr  = 1'b1;
    sw_rst_req = 1'b1;
    run_to(161);
    check_eq("clr_sw_cause", {29'd0, rst_cause}, 32'b010);
    check_eq("clr_sw_out", {29'd0, rst_out_n}, 32'b000);
    check_out("clr_sw_run", 185, 3'b111, 1'b0);

    // Five-cycle button glitch: no reset, ext cause untouched.
    run_to(200);
    ext_rst_btn_n = 1'b0;
    run_to(205);
    ext_rst_btn_n = 1'b1;
    check_out("glitch", 215, 3'b111, 1'b0);
    check_eq("glitch_cause", {29'd0, rst_cause}, 32'b010);

    run_to(220);
    cause_clr = 1'b1;
    run_to(221);
    check_eq("clr2", {29'd0, rst_cause}, 32'b000);

    // Button held low for 30 cycles from b=250.
    run_to(250);
    ext_rst_btn_n = 1'b0;
    check_out("btn_b9", 259, 3'b111, 1'b0);
    check_out("btn_b10", 260, 3'b000, 1'b1);
    run_to(261);
    check_eq("btn_cause", {29'd0, rst_cause}, 32'b001);
    run_to(280);
    ext_rst_btn_n = 1'b1;
    check_out("btn_held", 290, 3'b000, 1'b1);
    check_out("btn_c304", 304, 3'b000, 1'b1);
    check_out("btn_c305", 305, 3'b001, 1'b1);
    check_out("btn_run", 313, 3'b111, 1'b0);

    // Build cause 3'b110, then assert rst mid-RELEASE.
    run_to(320);
    cause_clr   = 1'b1;
    wdt_rst_req = 1'b1;
    run_to(321);
    check_eq("clr_wdt_cause", {29'd0, rst_cause}, 32'b100);
    run_to(330);
    sw_rst_req = 1'b1;
    check_out("mid_c348", 348, 3'b001, 1'b1);
    check_eq("mid_cause", {29'd0, rst_cause}, 32'b110);
    run_to(349);
    rst = 1'b1;
    run_to(350);
    rst = 1'b0;
    check_out("mid_rst", 350, 3'b000, 1'b1);
    check_eq("mid_rst_cause", {29'd0, rst_cause}, 32'b000);
    check_out("mid_c365", 365, 3'b000, 1'b1);
    check_out("mid_c366", 366, 3'b001, 1'b1);
    check_out("mid_c370", 370, 3'b011, 1'b1);
    check_out("mid_c374", 374, 3'b111, 1'b0);
    check_eq("mid_end_cause", {29'd0, rst_cause}, 32'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
